sort_topn: RTL and testbench

SORT_TOPN -- requirements
Module: sort_topn

---
 rtl/sort_pkg.sv | 25 ++
 rtl/sort_cell.sv | 62 ++++++
 rtl/sort_topn.sv | 168 ++++++++++++++++
 tb/tb_sort_topn.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants and width helpers for the top-N sorter.
// Consumers: sort_cell and sort_topn (optional sum path enabled by SORT_TOPN_SUM_EN).
package sort_pkg;

  localparam int DEF_W = 12;
  localparam int DEF_N = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int sum_width(input int w, input int n);
    return w + clog2(n);
  endfunction

  function automatic int count_width(input int n);
    return clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_cell.sv
// One stage of the systolic insertion array: compares the incoming sample,
// then holds, shifts in the upstream entry, or loads the sample.
import sort_pkg::*;

module sort_cell #(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_x,
  input  logic         clr,
  input  logic         set,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic [W-1:0] prev_val,
  input  logic         prev_vld,
  input  logic         prev_take,
  output logic         take,
  output logic [W-1:0] val,
  output logic         vld,
  output logic [W-1:0] nxt_val,
  output logic         nxt_vld
);

  logic [W-1:0] val_q, val_d;
  logic         vld_q, vld_d;

  // Strict compare keeps a new sample below any equal entries already held.
  always_comb begin
    take    = !vld_q || (din > val_q);
    nxt_val = val_q;
    nxt_vld = vld_q;
    if (en && take) begin
      if (prev_take) begin
        nxt_val = prev_val;
        nxt_vld = prev_vld;
      end else begin
        nxt_val = din;
        nxt_vld = 1'b1;
      end
    end
    val_d = nxt_val;
    vld_d = nxt_vld;
    if (clr) begin
      val_d = set ? din : '0;
      vld_d = set;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      val_q <= '0;
      vld_q <= 1'b0;
    end else begin
      val_q <= val_d;
      vld_q <= vld_d;
    end
  end

  assign val = val_q;
  assign vld = vld_q;

endmodule

// File: rtl/sort_topn.sv
// Retains the N largest samples of a frame and snapshots max/min/sum/count on FrameEnd.
// Define SORT_TOPN_SUM_EN to build the running-sum path; otherwise DataSumOut is 0.
import sort_pkg::*;

module sort_topn #(
  parameter  int W  = DEF_W,
  parameter  int N  = DEF_N,
  localparam int SW = sum_width(W, N),
  localparam int CW = count_width(N)
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          FrameStart,
  input  logic          DataEn,
  input  logic [W-1:0]  DataIn,
  input  logic          FrameEnd,
  output logic [W-1:0]  DataMax,
  output logic [W-1:0]  DataMin,
  output logic [SW-1:0] DataSumOut,
  output logic [CW-1:0] Count,
  output logic          OutValid
);

  logic [W-1:0] val_w      [N];
  logic [W-1:0] nxt_val_w  [N];
  logic [W-1:0] prev_val_w [N];
  logic [N-1:0] vld_w, nxt_vld_w, prev_vld_w, take_w, prev_take_w;

  // A clear that also carries a sample (and is not closing a frame) seeds a fresh frame.
  logic set_first;
  assign set_first = FrameStart && DataEn && !FrameEnd;

  for (genvar i = 0; i < N; i++) begin : g_cell
    if (i == 0) begin : g_head
      assign prev_val_w[i]  = '0;
      assign prev_vld_w[i]  = 1'b0;
      assign prev_take_w[i] = 1'b0;
    end else begin : g_body
      assign prev_val_w[i]  = val_w[i-1];
      assign prev_vld_w[i]  = vld_w[i-1];
      assign prev_take_w[i] = take_w[i-1];
    end

    sort_cell #(.W(W)) u_cell (
      .clk      (clk),
      .rst_x    (rst_x),
      .clr      (FrameStart),
      .set      ((i == 0) ? set_first : 1'b0),
      .en       (DataEn),
      .din      (DataIn),
      .prev_val (prev_val_w[i]),
      .prev_vld (prev_vld_w[i]),
      .prev_take(prev_take_w[i]),
      .take     (take_w[i]),
      .val      (val_w[i]),
      .vld      (vld_w[i]),
      .nxt_val  (nxt_val_w[i]),
      .nxt_vld  (nxt_vld_w[i])
    );
  end

  logic          accept;
  logic [W-1:0]  max_nxt, min_nxt;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [SW-1:0] sum_nxt;

  // The last cell taking the sample means it is retained rather than dropped.
  assign accept = DataEn && take_w[N-1];

  always_comb begin
    max_nxt = nxt_vld_w[0] ? nxt_val_w[0] : '0;
    min_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (nxt_vld_w[k]) begin
        min_nxt = nxt_val_w[k];
      end
    end
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (accept && !vld_w[N-1]) begin
      cnt_nxt = cnt_q + CW'(1);
    end
    cnt_d = cnt_nxt;
    if (FrameStart) begin
      cnt_d = set_first ? CW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef SORT_TOPN_SUM_EN
  logic [SW-1:0] sum_q, sum_d, evict;

  // Eviction only subtracts when the array was full before this sample.
  always_comb begin
    evict   = vld_w[N-1] ? SW'(val_w[N-1]) : '0;
    sum_nxt = sum_q;
    if (accept) begin
      sum_nxt = sum_q + SW'(DataIn) - evict;
    end
    sum_d = sum_nxt;
    if (FrameStart) begin
      sum_d = set_first ? SW'(DataIn) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`else
  assign sum_nxt = '0;
`endif

  logic [W-1:0]  data_max_q, data_max_d, data_min_q, data_min_d;
  logic [SW-1:0] data_sum_q, data_sum_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;

  // Snapshot the post-insertion, pre-clear view so a closing sample is counted.
  always_comb begin
    data_max_d  = data_max_q;
    data_min_d  = data_min_q;
    data_sum_d  = data_sum_q;
    count_d     = count_q;
    out_valid_d = FrameEnd;
    if (FrameEnd) begin
      data_max_d = max_nxt;
      data_min_d = min_nxt;
      data_sum_d = sum_nxt;
      count_d    = cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      data_max_q  <= '0;
      data_min_q  <= '0;
      data_sum_q  <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_max_q  <= data_max_d;
      data_min_q  <= data_min_d;
      data_sum_q  <= data_sum_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign DataMax    = data_max_q;
  assign DataMin    = data_min_q;
  assign DataSumOut = data_sum_q;
  assign Count      = count_q;
  assign OutValid   = out_valid_q;

endmodule

// File: tb/tb_sort_topn.sv
// Directed, table-driven bench for sort_topn with default W=12, N=16.
// Sum expectations follow the SORT_TOPN_SUM_EN build option.
module tb_sort_topn;

  logic        clk;
  logic        rst_x;
  logic        FrameStart;
  logic        DataEn;
  logic [11:0] DataIn;
  logic        FrameEnd;
  logic [11:0] DataMax;
  logic [11:0] DataMin;
  logic [15:0] DataSumOut;
  logic [4:0]  Count;
  logic        OutValid;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic        fs;
    logic        en;
    logic [11:0] din;
    logic        fe;
    logic        chk;
    int          eMax;
    int          eMin;
    int          eSum;
    int          eCnt;
  } vec_t;

  vec_t vecs[$];

  sort_topn dut (
    .clk       (clk),
    .rst_x     (rst_x),
    .FrameStart(FrameStart),
    .DataEn    (DataEn),
    .DataIn    (DataIn),
    .FrameEnd  (FrameEnd),
    .DataMax   (DataMax),
    .DataMin   (DataMin),
    .DataSumOut(DataSumOut),
    .Count     (Count),
    .OutValid  (OutValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int expSum(input int s);
`ifdef SORT_TOPN_SUM_EN
    return s;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared = nCompared + 1;
    if (act != exp) begin
      nMismatched = nMismatched + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int eMax, input int eMin,
                          input int eSum, input int eCnt, input int eValid);
    checkOutput({tag, " DataMax"}, int'(DataMax), eMax);
    checkOutput({tag, " DataMin"}, int'(DataMin), eMin);
    checkOutput({tag, " DataSumOut"}, int'(DataSumOut), expSum(eSum));
    checkOutput({tag, " Count"}, int'(Count), eCnt);
    checkOutput({tag, " OutValid"}, int'(OutValid), eValid);
  endtask

  task automatic addVec(input logic fs, input logic en, input int din, input logic fe);
    vec_t v;
    v.fs = fs; v.en = en; v.din = 12'(din); v.fe = fe; v.chk = 1'b0;
    v.eMax = 0; v.eMin = 0; v.eSum = 0; v.eCnt = 0;
    vecs.push_back(v);
  endtask

  task automatic addChk(input logic fs, input logic en, input int din, input logic fe,
                        input int eMax, input int eMin, input int eSum, input int eCnt);
    vec_t v;
    v.fs = fs; v.en = en; v.din = 12'(din); v.fe = fe; v.chk = 1'b1;
    v.eMax = eMax; v.eMin = eMin; v.eSum = eSum; v.eCnt = eCnt;
    vecs.push_back(v);
  endtask

  // Drives one cycle of inputs, lets the edge capture them, then samples 1 unit later.
  task automatic applyStimulus(input vec_t v);
    FrameStart = v.fs;
    DataEn     = v.en;
    DataIn     = v.din;
    FrameEnd   = v.fe;
    @(posedge clk);
    #1;
    FrameStart = 1'b0;
    DataEn     = 1'b0;
    DataIn     = '0;
    FrameEnd   = 1'b0;
  endtask

  initial begin
    vec_t v;
    nCompared   = 0;
    nMismatched = 0;
    rst_x       = 1'b0;
    FrameStart  = 1'b0;
    DataEn      = 1'b0;
    DataIn      = '0;
    FrameEnd    = 1'b0;

    // Frame of four mixed samples.
    addVec(1, 0, 0, 0);
    addVec(0, 1, 5, 0);
    addVec(0, 1, 3, 0);
    addVec(0, 1, 9, 0);
    addVec(0, 1, 1, 0);
    addChk(0, 0, 0, 1, 9, 1, 18, 4);
    // Ascending 1..20 overflows the array; the smallest four fall out.
    addVec(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) addVec(0, 1, i, 0);
    addChk(0, 0, 0, 1, 20, 5, 200, 16);
    // Sixteen 7s, then a tying 7 arriving with FrameEnd is dropped.
    addVec(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) addVec(0, 1, 7, 0);
    addChk(0, 1, 7, 1, 7, 7, 112, 16);
    // Clear-and-load over a full array.
    addVec(1, 1, 4095, 0);
    addChk(0, 0, 0, 1, 4095, 4095, 4095, 1);
    // FrameStart alone leaves the snapshot untouched; empty frame then reports zeros.
    addChk(1, 0, 0, 0, 4095, 4095, 4095, 1);
    addChk(0, 0, 0, 1, 0, 0, 0, 0);
    // Full-scale samples reach the top of the sum range.
    addVec(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) addVec(0, 1, 4095, 0);
    addChk(0, 0, 0, 1, 4095, 4095, 65520, 16);
    // FrameStart with FrameEnd snapshots the old frame, then the state is empty.
    addVec(1, 0, 0, 0);
    addVec(0, 1, 10, 0);
    addVec(0, 1, 20, 0);
    addChk(1, 0, 0, 1, 20, 10, 30, 2);
    addChk(0, 0, 0, 1, 0, 0, 0, 0);
    // Descending 100..85, then 90 evicts 85 and a tying 86 is dropped.
    addVec(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) addVec(0, 1, 100 - i, 0);
    addVec(0, 1, 90, 0);
    addVec(0, 1, 86, 0);
    addChk(0, 0, 0, 1, 100, 86, 1485, 16);

    #3;
    checkAll("in reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_x = 1'b1;
    @(posedge clk);
    #1;
    checkAll("after reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d OutValid", i), int'(OutValid), int'(vecs[i].fe));
      if (vecs[i].chk) begin
        checkOutput($sformatf("vec%0d DataMax", i), int'(DataMax), vecs[i].eMax);
        checkOutput($sformatf("vec%0d DataMin", i), int'(DataMin), vecs[i].eMin);
        checkOutput($sformatf("vec%0d DataSumOut", i), int'(DataSumOut), expSum(vecs[i].eSum));
        checkOutput($sformatf("vec%0d Count", i), int'(Count), vecs[i].eCnt);
      end
    end

    // OutValid must drop after its single-cycle pulse.
    @(posedge clk);
    #1;
    checkOutput("pulse end OutValid", int'(OutValid), 0);

    // Mid-frame reset clears outputs asynchronously and discards the frame.
    v = '{fs: 1'b1, en: 1'b0, din: 12'd0, fe: 1'b0, chk: 1'b0, eMax: 0, eMin: 0, eSum: 0, eCnt: 0};
    applyStimulus(v);
    v.fs = 1'b0; v.en = 1'b1; v.din = 12'd50;
    applyStimulus(v);
    v.din = 12'd60;
    applyStimulus(v);
    #2;
    rst_x = 1'b0;
    #1;
    checkAll("async reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_x = 1'b1;
    v.en = 1'b0; v.din = 12'd0; v.fe = 1'b1;
    applyStimulus(v);
    checkAll("post-reset frame", 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
